// File: rtl/ring_seq_pkg.sv
// Shared types and helpers for the ring/Johnson position sequencer.
package ring_seq_pkg;

    typedef enum logic {
        RING    = 1'b0,
        JOHNSON = 1'b1
    } mode_t;

    // Sequence period: N positions for one-hot rotate, 2*N for the twisted ring.
    function automatic int period(input int n, input mode_t m);
        return (m == JOHNSON) ? 2 * n : n;
    endfunction

endpackage

// File: rtl/ring_seq_decode.sv
// Combinational position-to-pattern decode for both sequence modes.
module ring_seq_decode
    import ring_seq_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(2 * N)
) (
    input  logic [PW-1:0] pos_i,
    input  mode_t         mode_i,
    output logic [N-1:0]  pat_o
);

    int p;

    // Johnson fills ones from the bottom for pos <= N, then drains them from the bottom.
    always_comb begin
        pat_o = '0;
        p     = int'(pos_i);
        for (int i = 0; i < N; i++) begin
            if (mode_i == RING)
                pat_o[i] = (p == i);
            else if (p <= N)
                pat_o[i] = (i < p);
            else
                pat_o[i] = (i >= p - N);
        end
    end

endmodule

// File: rtl/ring_sequencer.sv
// Ring / Johnson sequencer: registered position, decoded pattern and wrap pulse.
module ring_sequencer
    import ring_seq_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          dir,
    input  mode_t         mode,
    input  logic          load,
    input  logic [PW-1:0] load_pos,
    output logic [N-1:0]  q,
    output logic [PW-1:0] pos,
    output logic          wrap
);

    logic [PW-1:0] pos_q, pos_d;
    logic [N-1:0]  q_q, q_d;
    logic          wrap_q, wrap_d;
    mode_t         mode_q, mode_d;
    int            per;

    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        wrap_d = 1'b0;
        per    = period(N, mode_q);
        if (mode != mode_q) begin
            mode_d = mode;
            pos_d  = '0;
        end else if (load) begin
            pos_d = (int'(load_pos) < per) ? load_pos : '0;
        end else if (en) begin
            if (!dir) begin
                if (int'(pos_q) == per - 1) begin
                    pos_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q + PW'(1);
                end
            end else begin
                if (pos_q == '0) begin
                    pos_d  = PW'(per - 1);
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q - PW'(1);
                end
            end
        end
    end

    // Decoding the next position keeps q aligned with pos on the same edge.
    ring_seq_decode #(.N(N), .PW(PW)) u_decode (
        .pos_i  (pos_d),
        .mode_i (mode_d),
        .pat_o  (q_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_q  <= '0;
            mode_q <= RING;
            q_q    <= N'(1);
            wrap_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            mode_q <= mode_d;
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign pos  = pos_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_sequencer.sv
// Directed bench for ring_sequencer at N=4, with N=2 and N=8 copies for the period sweep.
module tb_ring_sequencer;
    import ring_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset, en, dir, load;
    mode_t      mode;
    logic [1:0] lp2;
    logic [2:0] lp4;
    logic [3:0] lp8;
    logic [1:0] q2, pos2;
    logic [3:0] q4;
    logic [2:0] pos4;
    logic [7:0] q8;
    logic [3:0] pos8;
    logic       w2, w4, w8;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0] j2 [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [3:0] j4 [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                           4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [3:0] r4 [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    always #5 clk = ~clk;

    ring_sequencer #(.N(2)) u_n2 (.clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_pos(lp2), .q(q2), .pos(pos2), .wrap(w2));
    ring_sequencer #(.N(4)) u_n4 (.clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_pos(lp4), .q(q4), .pos(pos4), .wrap(w4));
    ring_sequencer #(.N(8)) u_n8 (.clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_pos(lp8), .q(q8), .pos(pos8), .wrap(w8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; mode = RING;
        lp2 = '0; lp4 = '0; lp8 = '0;
        tick();
        chk("rst_pos", 32'(pos4), 0);
        chk("rst_q", 32'(q4), 32'b0001);
        chk("rst_wrap", 32'(w4), 0);
        chk("rst_q_n2", 32'(q2), 32'b01);
        chk("rst_q_n8", 32'(q8), 32'h01);

        // Forward ring, wrap only on 1000 -> 0001
        reset = 1'b1; en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("ring_fwd_q", 32'(q4), 32'(r4[k]));
            chk("ring_fwd_wrap", 32'(w4), (k == 3) ? 1 : 0);
        end

        en = 1'b0;
        tick();
        chk("hold_pos", 32'(pos4), 1);
        chk("hold_q", 32'(q4), 32'b0010);
        chk("hold_wrap", 32'(w4), 0);

        // Backward ring from 0
        load = 1'b1; lp4 = 3'd0;
        tick();
        chk("load0_pos", 32'(pos4), 0);
        chk("load0_q", 32'(q4), 32'b0001);
        load = 1'b0; dir = 1'b1; en = 1'b1;
        tick();
        chk("bwd_pos", 32'(pos4), 3);
        chk("bwd_q", 32'(q4), 32'b1000);
        chk("bwd_wrap", 32'(w4), 1);
        tick();
        chk("bwd2_pos", 32'(pos4), 2);
        chk("bwd2_q", 32'(q4), 32'b0100);
        chk("bwd2_wrap", 32'(w4), 0);
        dir = 1'b0;
        tick();
        chk("dirflip_pos", 32'(pos4), 3);
        chk("dirflip_wrap", 32'(w4), 0);

        // Johnson from reset: mode change cycle ignores en
        reset = 1'b0;
        tick();
        reset = 1'b1; mode = JOHNSON; en = 1'b1;
        tick();
        chk("jmode_pos", 32'(pos4), 0);
        chk("jmode_q", 32'(q4), 32'b0000);
        chk("jmode_wrap", 32'(w4), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("john_q", 32'(q4), 32'(j4[k]));
            chk("john_wrap", 32'(w4), (k == 7) ? 1 : 0);
        end

        // Load beats en; out-of-range load in ring lands on 0
        load = 1'b1; lp4 = 3'd6;
        tick();
        chk("jload_pos", 32'(pos4), 6);
        chk("jload_q", 32'(q4), 32'b1100);
        chk("jload_wrap", 32'(w4), 0);
        mode = RING; lp4 = 3'd5;
        tick();
        chk("rmode_pos", 32'(pos4), 0);
        chk("rmode_q", 32'(q4), 32'b0001);
        load = 1'b0;
        tick();
        chk("rstep_pos", 32'(pos4), 1);
        load = 1'b1;
        tick();
        chk("rload_oor_pos", 32'(pos4), 0);
        chk("rload_oor_q", 32'(q4), 32'b0001);
        chk("rload_oor_wrap", 32'(w4), 0);

        // Reset mid-Johnson, then Johnson mode reapplied after release
        load = 1'b0; en = 1'b0; mode = JOHNSON;
        tick();
        load = 1'b1; lp4 = 3'd5;
        tick();
        chk("j5_pos", 32'(pos4), 5);
        chk("j5_q", 32'(q4), 32'b1110);
        load = 1'b0; reset = 1'b0; en = 1'b1;
        tick();
        chk("midrst_pos", 32'(pos4), 0);
        chk("midrst_q", 32'(q4), 32'b0001);
        reset = 1'b1;
        tick();
        chk("postrst_pos", 32'(pos4), 0);
        chk("postrst_q", 32'(q4), 32'b0000);
        chk("postrst_wrap", 32'(w4), 0);

        // N=2 / N=8 ring sweep
        reset = 1'b0; mode = RING; en = 1'b0; dir = 1'b0;
        tick();
        reset = 1'b1; en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("n2_ring_pos", 32'(pos2), k % 2);
            chk("n2_ring_wrap", 32'(w2), (k % 2 == 0) ? 1 : 0);
            chk("n8_ring_pos", 32'(pos8), k % 8);
            chk("n8_ring_wrap", 32'(w8), (k % 8 == 0) ? 1 : 0);
        end
        chk("n8_ring_q", 32'(q8), 32'h01);

        // N=2 / N=8 Johnson sweep
        mode = JOHNSON;
        tick();
        chk("n8_jmode_q", 32'(q8), 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("n2_john_pos", 32'(pos2), k % 4);
            chk("n2_john_q", 32'(q2), 32'(j2[k % 4]));
            chk("n2_john_wrap", 32'(w2), (k % 4 == 0) ? 1 : 0);
            chk("n8_john_pos", 32'(pos8), k % 16);
            chk("n8_john_wrap", 32'(w8), (k % 16 == 0) ? 1 : 0);
        end
        chk("n8_john_q8", 32'(q8), 0);
        dir = 1'b1;
        tick();
        chk("n8_jbwd_pos", 32'(pos8), 15);
        chk("n8_jbwd_q", 32'(q8), 32'h80);
        chk("n8_jbwd_wrap", 32'(w8), 1);
        chk("n2_jbwd_pos", 32'(pos2), 3);
        chk("n2_jbwd_q", 32'(q2), 32'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_sequencer.md
RING_SEQUENCER -- requirements
Module: ring_sequencer

Interface
REQ-001 Parameter N, default 4, is the number of one-hot/Johnson outputs, with legal range 2..32.
REQ-002 Derived constant PW = $clog2(2*N) SHALL be the position-index width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-low reset.
REQ-005 en  input  1  SHALL, when high, advance the sequence one step per cycle.
REQ-006 dir  input  1  SHALL select step direction: 0 = forward (pos+1), 1 = backward (pos-1).
REQ-007 mode  input  1 (mode_t)  SHALL select the sequence: RING (one-hot rotate) or JOHNSON (twisted ring).
REQ-008 load  input  1  SHALL, when high, force the position to load_pos.
REQ-009 load_pos  input  PW  SHALL be the target position for load.
REQ-010 q  output  N  SHALL be the registered output pattern.
REQ-011 pos  output  PW  SHALL be the registered current position index.
REQ-012 wrap  output  1  SHALL be a registered one-cycle pulse marking sequence wrap-around.

Function
REQ-013 Period P SHALL be N in RING and 2*N in JOHNSON; pos SHALL always lie in 0..P-1.
REQ-014 RING decode: q = 1 << pos (N=4, pos 0..3 -> 0001, 0010, 0100, 1000).
REQ-015 JOHNSON decode: for pos <= N, q = (1<<pos)-1; for pos > N, q = ~((1<<(pos-N))-1) masked to N bits (N=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000).
REQ-016 q and pos SHALL change on the same edge; q always equals decode(pos, current mode) with zero added latency.
REQ-017 Per-cycle priority SHALL be: reset > mode change > load > en step > hold.
REQ-018 Mode change: when mode differs from the internally registered mode, pos SHALL go to 0, the new mode SHALL be registered, and load/en SHALL be ignored that cycle.
REQ-019 Load: pos <= load_pos if load_pos < P, else pos <= 0; en SHALL be ignored that cycle.
REQ-020 Step forward: pos <= (pos == P-1) ? 0 : pos+1; step backward: pos <= (pos == 0) ? P-1 : pos-1.
REQ-021 wrap SHALL be 1 in the cycle after an en step P-1->0 (forward) or 0->P-1 (backward), and 0 otherwise, including after load or mode change landing on 0.
REQ-022 With en low and no load or mode change, pos, q and the registered mode SHALL hold, and wrap SHALL be 0.
REQ-023 dir changes SHALL take effect on the next enabled step with no idle cycle.

Reset
REQ-024 On a clk edge with reset low: pos = 0, registered mode = RING, q = {N-1 zeros, 1}, wrap = 0, overriding all other inputs.
REQ-025 Reset mid-sequence SHALL take effect at that edge; the first step after reset release SHALL use the mode input of that cycle, applying REQ-018 first if mode is JOHNSON.

Structure
REQ-026 Package ring_seq_pkg SHALL hold the enum mode_t {RING, JOHNSON} and a function computing P from N and mode.
REQ-027 Sub-module ring_seq_decode (combinational: pos, mode -> N-bit pattern) SHALL be instantiated once on the next-pos path.
REQ-028 All storage SHALL live in one always_ff; next-state logic SHALL be in always_comb with full default assignments.

Verification (N=4 unless stated)
REQ-029 Reset, then mode=RING, en=1, dir=0 for 5 cycles -> q = 0010, 0100, 1000, 0001, 0010, with wrap=1 only alongside the 0001.
REQ-030 mode=JOHNSON from reset -> the first cycle gives pos=0, q=0000; then en=1 for 8 cycles -> q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, with wrap=1 at the final 0000.
REQ-031 RING with dir=1, en=1 from pos 0 -> pos=3, q=1000, wrap=1; the next step gives pos=2, q=0100, wrap=0.
REQ-032 JOHNSON with load=1, load_pos=6 and en=1 in the same cycle -> pos=6, q=1100, no step; then RING with load_pos=5 -> pos=0, q=0001, wrap=0.
REQ-033 JOHNSON at pos=5, then reset low for one cycle with en=1 -> pos=0, q=0001, mode RING; sweep N=2 and N=8 in both modes and check P and wrap.
